// File: rtl/imem_fetch_arbiter.sv
// Round-robin arbiter sharing the combinational instruction_memory read port between fetch (A) and debug (B).
// Optional IMEM_ARB_ALIGN_CHK_EN: misaligned granted reads are not forwarded and return an error response.
module imem_fetch_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              a_req_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  output logic              a_gnt_o,
  output logic              a_rvalid_o,
  output logic [DATA_W-1:0] a_rdata_o,
  output logic              a_rerr_o,
  input  logic              b_req_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  output logic              b_gnt_o,
  output logic              b_rvalid_o,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic              b_rerr_o,
  output logic [ADDR_W-1:0] iaddr_o,
  output logic              ird_o,
  input  logic [DATA_W-1:0] irdata_i
);

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_e;

  last_e             last_q, last_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              a_rerr_q, a_rerr_d;
  logic              b_rerr_q, b_rerr_d;

  logic              a_gnt, b_gnt, any_gnt, misalign;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] cap_data;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (reset_i) begin
      if (a_req_i && (!b_req_i || last_q == LAST_B)) begin
        a_gnt = 1'b1;
      end else if (b_req_i) begin
        b_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    any_gnt  = a_gnt | b_gnt;
    gnt_addr = '0;
    if (a_gnt) begin
      gnt_addr = a_addr_i;
    end else if (b_gnt) begin
      gnt_addr = b_addr_i;
    end
`ifdef IMEM_ARB_ALIGN_CHK_EN
    misalign = any_gnt && (gnt_addr[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    ird_o    = any_gnt & ~misalign;
    iaddr_o  = ird_o ? gnt_addr : '0;
    cap_data = misalign ? '0 : irdata_i;
  end

  always_comb begin
    last_d     = last_q;
    a_rvalid_d = a_gnt;
    b_rvalid_d = b_gnt;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    a_rerr_d   = a_rerr_q;
    b_rerr_d   = b_rerr_q;
    if (a_gnt) begin
      last_d    = LAST_A;
      a_rdata_d = cap_data;
      a_rerr_d  = misalign;
    end else if (b_gnt) begin
      last_d    = LAST_B;
      b_rdata_d = cap_data;
      b_rerr_d  = misalign;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      last_q     <= LAST_B;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_rerr_q   <= 1'b0;
      b_rerr_q   <= 1'b0;
    end else begin
      last_q     <= last_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      a_rerr_q   <= a_rerr_d;
      b_rerr_q   <= b_rerr_d;
    end
  end

  // A response registered just before reset asserts is suppressed during the reset cycle.
  assign a_gnt_o    = a_gnt;
  assign b_gnt_o    = b_gnt;
  assign a_rvalid_o = a_rvalid_q & reset_i;
  assign b_rvalid_o = b_rvalid_q & reset_i;
  assign a_rdata_o  = a_rdata_q;
  assign b_rdata_o  = b_rdata_q;
  assign a_rerr_o   = a_rerr_q;
  assign b_rerr_o   = b_rerr_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter with a small combinational instruction memory model.
module tb_imem_fetch_arbiter;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        a_req, b_req;
  logic [31:0] a_addr, b_addr;
  logic        a_gnt, a_rvalid, a_rerr;
  logic        b_gnt, b_rvalid, b_rerr;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] iaddr, irdata;
  logic        ird;

  int unsigned ntests = 0;
  int unsigned nfail  = 0;

  always #5 clk = ~clk;

  imem_fetch_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .a_req_i(a_req), .a_addr_i(a_addr), .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid),
    .a_rdata_o(a_rdata), .a_rerr_o(a_rerr),
    .b_req_i(b_req), .b_addr_i(b_addr), .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid),
    .b_rdata_o(b_rdata), .b_rerr_o(b_rerr),
    .iaddr_o(iaddr), .ird_o(ird), .irdata_i(irdata)
  );

  // Word-indexed memory contents; unlisted words read as the default word 1.
  always_comb begin
    case (iaddr[31:2])
      30'd0:   irdata = 32'h0111_1111;
      30'd1:   irdata = 32'h0000_1101;
      30'd2:   irdata = 32'h1011_0111;
      default: irdata = 32'h0000_0001;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs at the falling edge; sample one time unit later.
  task automatic step(input logic rst, input logic ar, input logic [31:0] aa,
                      input logic br, input logic [31:0] ba);
    @(negedge clk);
    reset_i = rst; a_req = ar; a_addr = aa; b_req = br; b_addr = ba;
    #1;
  endtask

  initial begin
    reset_i = 1'b0; a_req = 1'b0; b_req = 1'b0; a_addr = '0; b_addr = '0;

    // Reset held for two cycles with both requesting
    step(1'b0, 1'b1, 32'h8, 1'b1, 32'h100);
    chk("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
    chk("rst_b_gnt", {31'd0, b_gnt}, 32'd0);
    chk("rst_ird", {31'd0, ird}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    step(1'b0, 1'b1, 32'h8, 1'b1, 32'h100);
    chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_b_rdata", b_rdata, 32'd0);
    chk("rst_a_rerr", {31'd0, a_rerr}, 32'd0);
    chk("rst_b_rerr", {31'd0, b_rerr}, 32'd0);

    // Contention for four cycles: A,B,A,B
    step(1'b1, 1'b1, 32'h8, 1'b1, 32'h100);
    chk("c1_a_gnt", {31'd0, a_gnt}, 32'd1);
    chk("c1_b_gnt", {31'd0, b_gnt}, 32'd0);
    chk("c1_iaddr", iaddr, 32'h8);
    chk("c1_ird", {31'd0, ird}, 32'd1);
    step(1'b1, 1'b1, 32'h8, 1'b1, 32'h100);
    chk("c2_b_gnt", {31'd0, b_gnt}, 32'd1);
    chk("c2_a_gnt", {31'd0, a_gnt}, 32'd0);
    chk("c2_iaddr", iaddr, 32'h100);
    chk("c2_a_rvalid", {31'd0, a_rvalid}, 32'd1);
    chk("c2_a_rdata", a_rdata, 32'h1011_0111);
    chk("c2_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    step(1'b1, 1'b1, 32'h8, 1'b1, 32'h100);
    chk("c3_a_gnt", {31'd0, a_gnt}, 32'd1);
    chk("c3_b_rvalid", {31'd0, b_rvalid}, 32'd1);
    chk("c3_b_rdata", b_rdata, 32'h0000_0001);
    chk("c3_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    step(1'b1, 1'b1, 32'h8, 1'b1, 32'h100);
    chk("c4_b_gnt", {31'd0, b_gnt}, 32'd1);
    chk("c4_a_rvalid", {31'd0, a_rvalid}, 32'd1);
    step(1'b1, 1'b0, 32'h8, 1'b0, 32'h100);
    chk("c5_ird", {31'd0, ird}, 32'd0);
    chk("c5_iaddr", iaddr, 32'd0);
    chk("c5_b_rvalid", {31'd0, b_rvalid}, 32'd1);
    chk("c5_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("c6_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    chk("c6_b_rdata_hold", b_rdata, 32'h0000_0001);

    // A alone, back-to-back 0x0 then 0x4
    step(1'b1, 1'b1, 32'h0, 1'b0, 32'h0);
    chk("s1_a_gnt", {31'd0, a_gnt}, 32'd1);
    chk("s1_iaddr", iaddr, 32'h0);
    step(1'b1, 1'b1, 32'h4, 1'b0, 32'h0);
    chk("s2_a_gnt", {31'd0, a_gnt}, 32'd1);
    chk("s2_a_rvalid", {31'd0, a_rvalid}, 32'd1);
    chk("s2_a_rdata", a_rdata, 32'h0111_1111);
    chk("s2_b_gnt", {31'd0, b_gnt}, 32'd0);
    chk("s2_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("s3_a_rvalid", {31'd0, a_rvalid}, 32'd1);
    chk("s3_a_rdata", a_rdata, 32'h0000_1101);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("s4_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("s4_a_rdata_hold", a_rdata, 32'h0000_1101);

    // B granted once, then denied under contention and cancelled
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h200);
    chk("x1_b_gnt", {31'd0, b_gnt}, 32'd1);
    step(1'b1, 1'b1, 32'h8, 1'b1, 32'h204);
    chk("x2_a_gnt", {31'd0, a_gnt}, 32'd1);
    chk("x2_b_gnt", {31'd0, b_gnt}, 32'd0);
    chk("x2_b_rvalid", {31'd0, b_rvalid}, 32'd1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("x3_a_rvalid", {31'd0, a_rvalid}, 32'd1);
    chk("x3_a_rdata", a_rdata, 32'h1011_0111);
    chk("x3_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("x4_b_rvalid", {31'd0, b_rvalid}, 32'd0);

    // Reset asserted the cycle after an A grant drops the response
    step(1'b1, 1'b1, 32'h4, 1'b0, 32'h0);
    chk("r1_a_gnt", {31'd0, a_gnt}, 32'd1);
    step(1'b0, 1'b1, 32'h4, 1'b0, 32'h0);
    chk("r2_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("r2_a_gnt", {31'd0, a_gnt}, 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("r3_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("r3_a_rdata", a_rdata, 32'd0);
    step(1'b1, 1'b1, 32'h8, 1'b1, 32'h100);
    chk("r4_a_gnt", {31'd0, a_gnt}, 32'd1);
    chk("r4_b_gnt", {31'd0, b_gnt}, 32'd0);

    // Misaligned address 0x6
    step(1'b1, 1'b1, 32'h6, 1'b0, 32'h0);
    chk("m1_a_gnt", {31'd0, a_gnt}, 32'd1);
`ifdef IMEM_ARB_ALIGN_CHK_EN
    chk("m1_ird", {31'd0, ird}, 32'd0);
    chk("m1_iaddr", iaddr, 32'd0);
`else
    chk("m1_ird", {31'd0, ird}, 32'd1);
    chk("m1_iaddr", iaddr, 32'h6);
`endif
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("m2_a_rvalid", {31'd0, a_rvalid}, 32'd1);
`ifdef IMEM_ARB_ALIGN_CHK_EN
    chk("m2_a_rerr", {31'd0, a_rerr}, 32'd1);
    chk("m2_a_rdata", a_rdata, 32'd0);
`else
    chk("m2_a_rerr", {31'd0, a_rerr}, 32'd0);
    chk("m2_a_rdata", a_rdata, 32'h0000_1101);
`endif
    chk("m2_b_rerr", {31'd0, b_rerr}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_arbiter.md
# imem_fetch_arbiter

Two-requester arbiter and sequencer for the single-port, combinational `instruction_memory` read port. It shares that port between requester A (core fetch) and requester B (debug/loader read-back) using round-robin grant. Each read is registered into a one-cycle-latency response. It sits between the fetch stage and debug unit on one side and `instruction_memory` on the other.

## Interface
- `ADDR_W`, 32, address width (byte address)
- `DATA_W`, 32, instruction word width
- `clk_i`  in  1  clock; all logic on rising edge
- `reset_i`  in  1  synchronous, active-low reset
- `a_req_i`  in  1  requester A read request
- `a_addr_i`  in  ADDR_W  requester A byte address; held stable while `a_req_i`=1 and not granted
- `a_gnt_o`  out  1  requester A granted this cycle (combinational)
- `a_rvalid_o`  out  1  requester A response valid (registered)
- `a_rdata_o`  out  DATA_W  requester A response data
- `a_rerr_o`  out  1  requester A response error
- `b_req_i`, `b_addr_i`, `b_gnt_o`, `b_rvalid_o`, `b_rdata_o`, `b_rerr_o`: same as A, for requester B
- `iaddr_o`  out  ADDR_W  memory address
- `ird_o`  out  1  memory read enable
- `irdata_i`  in  DATA_W  memory read data (combinational from `iaddr_o`/`ird_o`)

## Operation
- State: `last_q` (1 bit, 0=A last granted, 1=B last granted); response registers per requester.
- Grant (combinational, from `*_req_i` and `last_q`):
  - only A requests -> grant A;
  - only B requests -> grant B;
  - both request -> grant the one not equal to `last_q`;
  - neither -> no grant.
- At most one `*_gnt_o` high per cycle.
- On a grant, drive the memory port for the granted requester:
  - `ird_o`=1;
  - `iaddr_o`=granted address.
- With no grant: `ird_o`=0 and `iaddr_o`=0.
- At the clock edge of a granted cycle:
  - capture `irdata_i` into the granted requester's `rdata` register;
  - set its `rvalid` for the next cycle;
  - set `last_q` to the granted requester.
- `rvalid` is a one-cycle pulse. It clears on the next edge unless that requester is granted again.
- `rdata` holds its last value when `rvalid`=0.
- Handshake:
  - request is accepted in the cycle `gnt`=1;
  - the requester may change address or drop `req` afterwards;
  - dropping `req` before grant is legal and cancels the request;
  - there is no response-side backpressure, so requesters must accept `rvalid` unconditionally.
- Back-to-back: a requester holding `req` alone is granted every cycle (throughput 1/cycle). Under constant contention, grants alternate A,B,A,B.

## Timing
- Grant latency: 0 cycles (same cycle as `req`, subject to arbitration).
- Response latency: exactly 1 cycle after grant.
- Worst-case wait under contention: 1 cycle.
- Reset (`reset_i`=0 at edge):
  - `last_q`=1, so A wins the first contention;
  - all `rvalid`, `rdata` and `rerr` registers clear to 0.
- Grants and `ird_o` are forced to 0 while `reset_i`=0.
- Reset mid-operation:
  - a response due in the next cycle is dropped (`rvalid` stays 0);
  - a pending request is not remembered;
  - the requester re-arbitrates after reset is released.
- An A grant and a B response in the same cycle (and the reverse) are independent and both legal.

## Configuration
- `IMEM_ARB_ALIGN_CHK_EN` defined:
  - a granted address with `addr[1:0]`!=0 is not forwarded, so `ird_o`=0 and `iaddr_o`=0 that cycle;
  - the requester still sees `gnt`=1;
  - next cycle it gets `rvalid`=1, `rerr`=1, `rdata`=0;
  - the grant still counts for round-robin (`last_q` updates).
- Not defined:
  - `*_rerr_o` tied to 0;
  - all granted addresses are forwarded unmodified, and memory uses `addr[31:2]`.

## Test plan
- Reset: hold `reset_i`=0 for 2 cycles with both `req`=1 -> no `gnt`, `ird_o`=0, all `rvalid`=0. Release -> first grant is A.
- Single requester: A requests 0x0 then 0x4 back-to-back -> `a_gnt_o`=1 both cycles; `a_rvalid_o` 1 cycle later with data 0x01111111 then 0x00001101; `b_*` stay 0.
- Contention: both hold `req` for 4 cycles, A addr 0x8, B addr 0x100 -> grants A,B,A,B; A rdata 0x10110111; B rdata 0x00000001 (default word).
- Cancel and reset mid-flight: B requests, is denied, then drops `req` -> no B response. Assert reset in the cycle after an A grant -> `a_rvalid_o` stays 0.
- Alignment, macro defined: A requests 0x6 -> `a_gnt_o`=1, `ird_o`=0; next cycle `a_rvalid_o`=1, `a_rerr_o`=1, `a_rdata_o`=0.
- Alignment, macro undefined: A requests 0x6 -> response is the word at 0x4 (0x00001101) with `rerr`=0.
